ei_axi4_rst_ctrl: RTL and testbench

- Synthesizable, parametrised reset/watchdog controller for the AXI4 VIP environment; replaces ad-hoc reset pulses and fixed-time finish.
- Fans the master active-low reset out to NUM_RST independently maskable reset domains (master, slave, monitor, ...).
- Provides runtime reset injection with programmable delay and a watchdog that flags bus inactivity.

---
 rtl/ei_axi4_rst_ctrl_if.sv | 27 ++
 rtl/ei_axi4_rst_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ei_axi4_rst_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ei_axi4_rst_ctrl_if.sv
// Request/status bundle between the reset/watchdog controller and the VIP environment.
// The master side drives injection requests and activity; the slave side returns resets and status.
interface ei_axi4_rst_ctrl_if #(
  parameter int unsigned NUM_RST = 2,
  parameter int unsigned DLY_W   = 16,
  parameter int unsigned CNT_W   = 32
);
  logic               inj_req;
  logic [DLY_W-1:0]   inj_delay;
  logic [NUM_RST-1:0] inj_mask;
  logic               activity;
  logic [NUM_RST-1:0] rst_n_out;
  logic               inj_busy;
  logic               inj_done;
  logic               timeout;
  logic [CNT_W-1:0]   cycle_cnt;

  modport master (
    output inj_req, inj_delay, inj_mask, activity,
    input  rst_n_out, inj_busy, inj_done, timeout, cycle_cnt
  );

  modport slave (
    input  inj_req, inj_delay, inj_mask, activity,
    output rst_n_out, inj_busy, inj_done, timeout, cycle_cnt
  );
endinterface

// File: rtl/ei_axi4_rst_ctrl.sv
// Reset fan-out controller: power-on hold, delayed per-domain reset injection,
// bus-inactivity watchdog and a saturating cycle counter.
module ei_axi4_rst_ctrl #(
  parameter int unsigned NUM_RST        = 2,
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned DLY_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 250,
  parameter int unsigned CNT_W          = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  ei_axi4_rst_ctrl_if.slave bus
);

  localparam int unsigned        HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  H_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  H_FULL  = HOLD_W'(HOLD_CYCLES);
  localparam logic [NUM_RST-1:0] ALL_ON  = '1;
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam bit                 WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]   WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  generate
    if (NUM_RST < 1 || HOLD_CYCLES < 1) begin : g_param_err
      $error("ei_axi4_rst_ctrl: NUM_RST and HOLD_CYCLES must both be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    POR_HOLD = 2'd0,
    IDLE     = 2'd1,
    DELAY    = 2'd2,
    INJECT   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [DLY_W-1:0]   r_dly_cnt;
  logic [DLY_W-1:0]   w_dly_nxt;
  logic [NUM_RST-1:0] r_mask;
  logic [NUM_RST-1:0] w_mask_nxt;
  logic [NUM_RST-1:0] r_rst_n;
  logic [NUM_RST-1:0] w_rst_n_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_wd_cnt;
  logic [CNT_W-1:0]   w_wd_nxt;
  logic [CNT_W-1:0]   r_cycle_cnt;
  logic               w_accept;
  logic               w_hold_last;
  logic               w_hold_full;
  logic               w_wd_clr;
  logic               w_expire;

  assign w_accept    = bus.inj_req && (bus.inj_mask != '0);
  assign w_hold_last = (r_hold_cnt == H_LAST);
  assign w_hold_full = (r_hold_cnt == H_FULL);

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= POR_HOLD;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      POR_HOLD: if (w_hold_last) w_state_nxt = IDLE;
      IDLE:     if (w_accept) w_state_nxt = (bus.inj_delay == '0) ? INJECT : DELAY;
      DELAY:    if (r_dly_cnt == '0) w_state_nxt = INJECT;
      INJECT:   if (w_hold_full) w_state_nxt = IDLE;
      default:  w_state_nxt = POR_HOLD;
    endcase
  end

  // Output and sequence-counter next values; a zero-delay injection enters INJECT
  // with hold_cnt=0, so its first INJECT edge is the one that pulls the domains low.
  always_comb begin
    w_hold_nxt  = r_hold_cnt;
    w_dly_nxt   = r_dly_cnt;
    w_mask_nxt  = r_mask;
    w_rst_n_nxt = r_rst_n;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      POR_HOLD: begin
        if (w_hold_last) begin
          w_hold_nxt  = '0;
          w_rst_n_nxt = ALL_ON;
          w_busy_nxt  = 1'b0;
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      IDLE: begin
        if (w_accept) begin
          w_mask_nxt = bus.inj_mask;
          w_dly_nxt  = bus.inj_delay;
          w_hold_nxt = '0;
          w_busy_nxt = 1'b1;
        end
      end
      DELAY: begin
        if (r_dly_cnt == '0) begin
          w_rst_n_nxt = ~r_mask;
          w_hold_nxt  = HOLD_W'(1);
        end else begin
          w_dly_nxt = r_dly_cnt - DLY_W'(1);
        end
      end
      INJECT: begin
        if (w_hold_full) begin
          w_rst_n_nxt = ALL_ON;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_hold_nxt  = '0;
        end else begin
          w_rst_n_nxt = ~r_mask;
          w_hold_nxt  = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        w_hold_nxt = '0;
      end
    endcase
  end

  // Watchdog: any held-low domain counts as "not idle"; activity beats expiry
  assign w_wd_clr = bus.activity || (r_rst_n != ALL_ON);
  assign w_wd_nxt = w_wd_clr ? '0 :
                    ((r_wd_cnt == CNT_MAX) ? r_wd_cnt : r_wd_cnt + CNT_W'(1));
  assign w_expire = WD_EN && !bus.activity && (r_wd_cnt == WD_LAST);

  // Registered outputs and counters
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_hold_cnt  <= '0;
      r_dly_cnt   <= '0;
      r_mask      <= '0;
      r_rst_n     <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_wd_cnt    <= '0;
      r_cycle_cnt <= '0;
    end else begin
      r_hold_cnt  <= w_hold_nxt;
      r_dly_cnt   <= w_dly_nxt;
      r_mask      <= w_mask_nxt;
      r_rst_n     <= w_rst_n_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_wd_cnt    <= w_wd_nxt;
      if (w_expire) r_timeout <= 1'b1;
      if (r_cycle_cnt != CNT_MAX) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
    end
  end

  assign bus.rst_n_out = r_rst_n;
  assign bus.inj_busy  = r_busy;
  assign bus.inj_done  = r_done;
  assign bus.timeout   = r_timeout;
  assign bus.cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_ei_axi4_rst_ctrl.sv
// Scoreboard bench: two controller instances (small and default watchdog/counter sizes)
// share one stimulus stream; a window-based reference model predicts every edge.
module tb_ei_axi4_rst_ctrl;

  localparam int unsigned NR   = 2;
  localparam int unsigned HOLD = 4;
  localparam int unsigned DW   = 16;
  localparam int unsigned TO_A = 8;
  localparam int unsigned CW_A = 4;
  localparam int unsigned TO_B = 250;
  localparam int unsigned CW_B = 32;
  localparam int          CMAX_A = 15;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  ei_axi4_rst_ctrl_if #(.NUM_RST(NR), .DLY_W(DW), .CNT_W(CW_A)) bus_a ();
  ei_axi4_rst_ctrl_if #(.NUM_RST(NR), .DLY_W(DW), .CNT_W(CW_B)) bus_b ();

  ei_axi4_rst_ctrl #(.NUM_RST(NR), .HOLD_CYCLES(HOLD), .DLY_W(DW),
                     .TIMEOUT_CYCLES(TO_A), .CNT_W(CW_A))
    u_dut_a (.aclk(aclk), .aresetn(aresetn), .bus(bus_a));

  ei_axi4_rst_ctrl #(.NUM_RST(NR), .HOLD_CYCLES(HOLD), .DLY_W(DW),
                     .TIMEOUT_CYCLES(TO_B), .CNT_W(CW_B))
    u_dut_b (.aclk(aclk), .aresetn(aresetn), .bus(bus_b));

  typedef struct {
    int          idx;
    logic [1:0]  rst;
    logic        busy;
    logic        done;
    logic        to_a;
    logic        to_b;
    logic [31:0] cyc_a;
    logic [31:0] cyc_b;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference-model state: edges are numbered from the first driven edge
  int         n = 0;
  int         rel = 0;
  bit         inj_act = 0;
  logic [1:0] inj_mask_l = 2'b00;
  int         lo_s = 0;
  int         hi_e = 0;
  bit         m_to_a = 0;
  bit         m_to_b = 0;
  int         l_a = 0;
  int         l_b = 0;
  logic [1:0] prev_rst = 2'b00;

  task automatic chk(input string nm, input int idx, input longint unsigned got,
                     input longint unsigned want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", nm, idx, got, want);
    end
  endtask

  // Drive one edge's inputs and push what both instances must show after that edge
  task automatic step(input logic rstn, input logic req, input int unsigned dly,
                      input logic [1:0] mask, input logic act);
    exp_t e;
    @(negedge aclk);
    #1;
    aresetn         = rstn;
    bus_a.inj_req   = req;   bus_b.inj_req   = req;
    bus_a.inj_delay = DW'(dly); bus_b.inj_delay = DW'(dly);
    bus_a.inj_mask  = mask;  bus_b.inj_mask  = mask;
    bus_a.activity  = act;   bus_b.activity  = act;

    e.idx = n; e.done = 1'b0;
    if (!rstn) begin
      rel = 0; inj_act = 0; done_q.delete();
      m_to_a = 0; m_to_b = 0; l_a = n; l_b = n;
      e.rst = 2'b00; e.busy = 1'b1;
    end else begin
      rel++;
      if (rel < int'(HOLD)) begin
        e.rst = 2'b00; e.busy = 1'b1;
      end else if (rel == int'(HOLD)) begin
        e.rst = 2'b11; e.busy = 1'b0;
      end else if (inj_act) begin
        if (n == hi_e) begin
          e.rst = 2'b11; e.busy = 1'b0; e.done = 1'b1; inj_act = 0;
        end else begin
          e.rst  = (n >= lo_s) ? ~inj_mask_l : 2'b11;
          e.busy = 1'b1;
        end
      end else if (req && mask != 2'b00) begin
        inj_act = 1; inj_mask_l = mask;
        lo_s = n + int'(dly) + 1; hi_e = lo_s + int'(HOLD);
        done_q.push_back(hi_e);
        e.rst = 2'b11; e.busy = 1'b1;
      end else begin
        e.rst = 2'b11; e.busy = 1'b0;
      end
      if (!act && (n - 1 - l_a) == int'(TO_A) - 1) m_to_a = 1;
      if (!act && (n - 1 - l_b) == int'(TO_B) - 1) m_to_b = 1;
      if (act || prev_rst != 2'b11) begin
        l_a = n; l_b = n;
      end
    end
    e.to_a  = m_to_a;
    e.to_b  = m_to_b;
    e.cyc_a = 32'((rel > CMAX_A) ? CMAX_A : rel);
    e.cyc_b = 32'(rel);
    prev_rst = e.rst;
    exp_q.push_back(e);
    n++;
  endtask

  task automatic idle(input int k, input logic act);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 0, 2'b00, act);
  endtask

  // Monitor: one expected record per edge, plus done pulses matched against their scheduled edge
  initial begin : monitor
    exp_t e;
    int   mon_edge;
    int   d;
    mon_edge = -1;
    forever begin
      @(negedge aclk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        mon_edge++;
        chk("rst_n_out_a", e.idx, bus_a.rst_n_out, e.rst);
        chk("rst_n_out_b", e.idx, bus_b.rst_n_out, e.rst);
        chk("inj_busy_a",  e.idx, bus_a.inj_busy,  e.busy);
        chk("inj_busy_b",  e.idx, bus_b.inj_busy,  e.busy);
        chk("inj_done_a",  e.idx, bus_a.inj_done,  e.done);
        chk("inj_done_b",  e.idx, bus_b.inj_done,  e.done);
        chk("timeout_a",   e.idx, bus_a.timeout,   e.to_a);
        chk("timeout_b",   e.idx, bus_b.timeout,   e.to_b);
        chk("cycle_cnt_a", e.idx, bus_a.cycle_cnt, e.cyc_a);
        chk("cycle_cnt_b", e.idx, bus_b.cycle_cnt, e.cyc_b);
        if (bus_a.inj_done) begin
          if (done_q.size() == 0) begin
            total++; bad++;
            $display("FAIL done_unexpected edge=%0d got=1 want=0", mon_edge);
          end else begin
            d = done_q.pop_front();
            chk("done_edge", mon_edge, longint'(mon_edge), longint'(d));
          end
        end
      end
    end
  end

  initial begin : stimulus
    bus_a.inj_req = 1'b0; bus_a.inj_delay = '0; bus_a.inj_mask = '0; bus_a.activity = 1'b0;
    bus_b.inj_req = 1'b0; bus_b.inj_delay = '0; bus_b.inj_mask = '0; bus_b.activity = 1'b0;

    // Power-on
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 2'b00, 1'b0);
    idle(6, 1'b0);

    // Delayed injection, one domain
    step(1'b1, 1'b1, 5, 2'b10, 1'b0);
    idle(12, 1'b0);

    // Zero-delay injection with an ignored request while busy, then a zero-mask request
    step(1'b1, 1'b1, 0, 2'b11, 1'b0);
    step(1'b1, 1'b0, 0, 2'b00, 1'b0);
    step(1'b1, 1'b1, 3, 2'b01, 1'b0);
    idle(5, 1'b0);
    step(1'b1, 1'b1, 2, 2'b00, 1'b0);
    idle(3, 1'b0);

    // Back-to-back: new request on the edge right after inj_done
    step(1'b1, 1'b1, 2, 2'b01, 1'b0);
    idle(7, 1'b0);
    step(1'b1, 1'b1, 1, 2'b10, 1'b0);
    idle(10, 1'b0);

    // Mid-operation reset aborts a long injection
    step(1'b1, 1'b1, 10, 2'b11, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 1'b0, 0, 2'b00, 1'b0);
    idle(8, 1'b0);

    // Watchdog expiry after activity, sticky despite later activity
    step(1'b0, 1'b0, 0, 2'b00, 1'b0);
    idle(4, 1'b0);
    step(1'b1, 1'b0, 0, 2'b00, 1'b1);
    idle(8, 1'b0);
    idle(3, 1'b1);

    // Rerun: activity on E7 resets the count, expiry only later
    step(1'b0, 1'b0, 0, 2'b00, 1'b0);
    idle(4, 1'b0);
    step(1'b1, 1'b0, 0, 2'b00, 1'b1);
    idle(6, 1'b0);
    step(1'b1, 1'b0, 0, 2'b00, 1'b1);
    idle(12, 1'b0);

    // Counter saturation on the narrow instance
    idle(20, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 900; i++) begin
      step(logic'($urandom_range(63) != 0), logic'($urandom_range(4) == 0),
           $urandom_range(12), 2'($urandom_range(3)), logic'($urandom_range(9) == 0));
    end
    idle(24, 1'b0);

    @(negedge aclk);
    #2;
    chk("done_pending", n, longint'(done_q.size()), 0);
    chk("exp_pending",  n, longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
